// File: rtl/gf256_inv_seq_if.sv
// Valid/ready handshake bundle for the GF(2^8) composite-field inverter:
// operand stream in, inverse stream out.
interface gf256_inv_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/gf256_inv_seq.sv
// Iterative GF((2^4)^2) inverter: one shared GF(2^4) multiplier is reused
// across five multiply states; d^-1 is formed as d^14 = (d^7)^2.

module mul_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);
  logic [6:0] raw;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so each path is fully specified and no latch is inferred.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) raw = raw ^ ({3'b000, a} << i);
    end
    // Fold x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2 back into four bits.
    p[0] = raw[0] ^ raw[4];
    p[1] = raw[1] ^ raw[4] ^ raw[5];
    p[2] = raw[2] ^ raw[5] ^ raw[6];
    p[3] = raw[3] ^ raw[6];
  end
endmodule

module gf256_inv_seq #(
  // Extension-field constant; must have trace 1 (4'hE and 4'hC qualify).
  parameter logic [3:0] LAMBDA = 4'hE
) (
  input logic            clk,
  input logic            rst,
  gf256_inv_seq_if.slave io
);
  typedef enum logic [2:0] {
    IDLE,
    M_D,
    M_D3,
    M_D7,
    M_OH,
    M_OL,
    DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] ah, al, d, t, dinv;
  logic [3:0] mul_a, mul_b, mul_p;
  logic [7:0] dout_q;
  logic       out_valid_q;

  function automatic logic [3:0] sq(input logic [3:0] a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  function automatic logic [3:0] xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // Multiply by the constant LAMBDA; folds to a small XOR network.
  function automatic logic [3:0] mul_lambda(input logic [3:0] a);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (LAMBDA[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  mul_core u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_a     = ah;
    mul_b     = al;
    unique case (state)
      IDLE: begin
        if (io.in_valid) state_nxt = M_D;
      end
      M_D: begin
        mul_a     = ah;
        mul_b     = al;
        state_nxt = M_D3;
      end
      M_D3: begin
        mul_a     = sq(d);
        mul_b     = d;
        state_nxt = M_D7;
      end
      M_D7: begin
        mul_a     = sq(t);
        mul_b     = d;
        state_nxt = M_OH;
      end
      M_OH: begin
        mul_a     = ah;
        mul_b     = dinv;
        state_nxt = M_OL;
      end
      M_OL: begin
        mul_a     = ah ^ al;
        mul_b     = dinv;
        state_nxt = DONE;
      end
      DONE: begin
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ah          <= '0;
      al          <= '0;
      d           <= '0;
      t           <= '0;
      dinv        <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            ah <= io.din[7:4];
            al <= io.din[3:0];
          end
        end
        M_D:  d    <= mul_p ^ mul_lambda(sq(ah)) ^ sq(al);
        M_D3: t    <= mul_p;
        M_D7: dinv <= sq(mul_p);
        M_OH: dout_q[7:4] <= mul_p;
        M_OL: begin
          dout_q[3:0] <= mul_p;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (io.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;
endmodule

// File: doc/gf256_inv_seq.md
# gf256_inv_seq

Iterative multiplicative inverter for GF(2^8) in the composite-field representation GF((2^4)^2). It is the inversion stage of the composite-field AES S-box. The isomorphic mapping upstream feeds it 8-bit composite-field elements, and its results go to the inverse mapping and affine stage downstream. One shared GF(2^4) multiplier (mul_core, polynomial x^4+x+1) is time-multiplexed across five multiply steps under a small FSM, with a valid/ready handshake on both sides.

## Interface
- LAMBDA, 4'hE, constant λ of the extension polynomial y^2 + y + λ over GF(2^4). Must have trace 1; 4'hE and 4'hC are valid.
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- din  input  8  operand; din[7:4] = ah (high coefficient), din[3:0] = al.
- out_valid  output  1  dout holds a finished result.
- out_ready  input  1  downstream accepts dout.
- dout  output  8  inverse; dout[7:4] = high coefficient, dout[3:0] = low coefficient.

## Operation
- Element value = ah·y + al, with y^2 = y + λ. All GF(2^4) arithmetic is modulo x^4+x+1.
- Math:
  - d = λ·ah^2 + ah·al + al^2
  - d^-1 = d^14
  - result high = ah·d^-1
  - result low = (ah ^ al)·d^-1
  - Input 0 yields 0.
- Combinational helpers, none of which use the multiplier:
  - square sq(a) = {a3, a1^a3, a2, a0^a2}
  - constant multiply by LAMBDA
  - XOR
- Exactly one mul_core instance. Its operands are muxed by state; its product is registered each multiply state.
- FSM states: IDLE, M_D, M_D3, M_D7, M_OH, M_OL, DONE.
  - IDLE: in_ready=1. If in_valid, latch ah and al, then go to M_D.
  - M_D: product ah·al. Register d = product ^ LAMBDA·sq(ah) ^ sq(al). Go to M_D3.
  - M_D3: product sq(d)·d, registered as t (= d^3). Go to M_D7.
  - M_D7: product sq(t)·d (= d^7). Register dinv = sq(d^7). Go to M_OH.
  - M_OH: product ah·dinv, registered into dout[7:4]. Go to M_OL.
  - M_OL: product (ah^al)·dinv, registered into dout[3:0]. Go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE; else hold.
- dout and out_valid are registered outputs and change only on state transitions.
- dout is stable and held unchanged while out_valid=1 and out_ready=0.
- in_valid seen in any state other than IDLE is ignored; the operand is not consumed.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE; dout=8'h00, out_valid=0, in_ready=1 on the same assertion, with no clock required. Internal registers clear to 0.
- Reset mid-operation abandons the computation. No result appears after reset is released.
- Acceptance at edge N (in_ready & in_valid). in_ready drops after edge N.
- out_valid rises after edge N+5, when M_OL completes into DONE. Latency is 5 cycles.
- Output handshake at edge M (out_valid & out_ready). out_valid falls and in_ready rises after edge M.
- Earliest next acceptance is edge M+1. With out_ready tied high, throughput is one result per 7 cycles.
- in_valid and out_ready asserted together in DONE: only the output transfer occurs that cycle.

## Test plan
- Reset: assert rst asynchronously mid-M_D7 -> immediately dout=00, out_valid=0, in_ready=1. After release, no stale result appears.
- Basic values with LAMBDA=E and out_ready=1:
  - din=01 -> dout=01
  - din=02 -> dout=09
  - din=10 -> dout=33
  - din=00 -> dout=00
  - Each out_valid appears exactly 5 cycles after acceptance.
- Exhaustive: all 255 nonzero inputs. The checker multiplies din·dout in the composite field and requires 8'h01. Plus 00 -> 00.
- Backpressure: din=10 with out_ready=0 for 10 cycles -> dout held at 33 and out_valid held high. in_ready stays 0 and a new in_valid is ignored. Releasing out_ready completes the transfer, and in_ready rises next cycle.
- Back-to-back: in_valid held high with a stream 01, 02, 10 and out_ready=1 -> results 01, 09, 33 in order, one per 7 cycles, none dropped or duplicated.
- Random: random in_valid/out_ready toggling over 1000 operands against a software model -> no mismatches or protocol violations.
